// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit -- multiply/divide unit for the execute stage.
//
// Accepts mult/multu/div/divu requests from the E stage. It computes the
// 64-bit result in the request cycle and holds it. It then raises busy for a
// fixed number of cycles before committing the result to HI/LO. mthi/mtlo
// write HI/LO directly when the unit is idle. Requests that arrive while the
// unit is busy are dropped. The hazard unit normally keeps such requests
// from reaching this block, so this is only a safety measure.
//
// Parameters:
//   MULT_CYCLES  cycles busy is held for mult/multu (>= 1)
//   DIV_CYCLES   cycles busy is held for div/divu   (>= 1)
//
// Ports:
//   clk     in   1   clock; all state changes on posedge
//   rst     in   1   synchronous, active-high reset
//   md_en   in   1   md_op is valid this cycle
//   md_op   in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                    7 reserved (no effect)
//   rs_val  in  32   rs operand (dividend / multiplicand / mthi-mtlo source)
//   rt_val  in  32   rt operand (divisor / multiplier)
//   busy    out  1   operation in progress; HI/LO not yet updated
//   hi      out 32   HI register
//   lo      out 32   LO register
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        md_en,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ---------------------------------------------------------------------
    // State and data registers
    // ---------------------------------------------------------------------
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [63:0]        r_result;
    logic               r_div_zero;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    // ---------------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------------
    logic w_is_mult;
    logic w_is_div;
    logic w_is_long_op;

    assign w_is_mult    = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign w_is_div     = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign w_is_long_op = w_is_mult || w_is_div;

    // ---------------------------------------------------------------------
    // Multiply: the low 64 bits of a product are the same whether the
    // operands are treated as signed or unsigned, once they are extended
    // to 64 bits. So a single unsigned 64x64 multiply serves both ops. Only
    // the extension differs.
    // ---------------------------------------------------------------------
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;

    assign w_mul_a = (md_op == OP_MULT) ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
    assign w_mul_b = (md_op == OP_MULT) ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
    assign w_prod  = w_mul_a * w_mul_b;

    // ---------------------------------------------------------------------
    // Divide: a signed divide runs as an unsigned divide on magnitudes and
    // then fixes the signs. This avoids the INT_MIN / -1 overflow. The
    // magnitude of 0x80000000 is 0x80000000 as an unsigned value. The
    // quotient then comes out as 0x80000000 and the remainder as 0, which
    // is the required result. A zero divisor is replaced by 1 so the divider
    // never sees an undefined case. That result is discarded at commit.
    // ---------------------------------------------------------------------
    logic        w_div_signed;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs_raw;
    logic [31:0] w_dvs;
    logic [31:0] w_quo_u;
    logic [31:0] w_rem_u;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_div_zero;

    assign w_div_signed = (md_op == OP_DIV);
    assign w_rs_neg     = w_div_signed && rs_val[31];
    assign w_rt_neg     = w_div_signed && rt_val[31];
    assign w_dvd        = w_rs_neg ? (~rs_val + 32'd1) : rs_val;
    assign w_dvs_raw    = w_rt_neg ? (~rt_val + 32'd1) : rt_val;
    assign w_div_zero   = (rt_val == 32'd0);
    assign w_dvs        = w_div_zero ? 32'd1 : w_dvs_raw;
    assign w_quo_u      = w_dvd / w_dvs;
    assign w_rem_u      = w_dvd % w_dvs;
    // Quotient is negative when the operand signs differ; the remainder
    // takes the sign of the dividend.
    assign w_quo        = (w_rs_neg ^ w_rt_neg) ? (~w_quo_u + 32'd1) : w_quo_u;
    assign w_rem        = w_rs_neg ? (~w_rem_u + 32'd1) : w_rem_u;

    logic [63:0] w_result;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        w_result = 64'd0;
        if (w_is_mult) begin
            w_result = w_prod;
        end else if (w_is_div) begin
            w_result = {w_rem, w_quo};
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state, counter and control strobes
    // ---------------------------------------------------------------------
    state_t           w_next_state;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_start;
    logic             w_commit;

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_start      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (md_en && w_is_long_op) begin
                    w_start      = 1'b1;
                    w_cnt_next   = w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                // Requests in RUN are ignored entirely. The edge where the
                // count reaches zero is the commit edge.
                if (r_cnt <= CNT_W'(1)) begin
                    w_commit     = 1'b1;
                    w_cnt_next   = '0;
                    w_next_state = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // ---------------------------------------------------------------------
    // Operation capture at the request edge
    // ---------------------------------------------------------------------
    // NOTE: these registers are deliberately not reset. They are always
    // written at the request edge before commit reads them, and a reset
    // forces the FSM back to IDLE, so a stale value is never committed.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_op       <= md_op;
            r_result   <= w_result;
            r_div_zero <= w_is_div && w_div_zero;
        end
    end

    // Divide-by-zero keeps HI/LO unchanged but still takes the full latency.
    logic w_commit_ok;
    assign w_commit_ok = !(r_div_zero && ((r_op == OP_DIV) || (r_op == OP_DIVU)));

    // ---------------------------------------------------------------------
    // HI / LO
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            if (w_commit_ok) begin
                r_hi <= r_result[63:32];
                r_lo <= r_result[31:0];
            end
        end else if ((r_state == S_IDLE) && md_en) begin
            if (md_op == OP_MTHI) begin
                r_hi <= rs_val;
            end
            if (md_op == OP_MTLO) begin
                r_lo <= rs_val;
            end
        end
    end

    // busy comes straight from the state flop, so it is a registered output.
    assign busy = (r_state == S_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
